// File: rtl/control_sequencer.sv
// Control sequencer: a Moore FSM that walks the fetch and ALU-immediate
// execute steps and produces registered datapath strobes for each step.
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Mem_Ready,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZLO_Out,
  output logic        C_Out,
  output logic        BA_Out,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        MAR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZLO_In,
  output logic        R_In,
  output logic        IncPC,
  output logic        Read,
  output logic        G_RA,
  output logic        G_RB,
  output logic [4:0]  CONTROL,
  output logic        Run,
  output logic        Fault
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    HALTED = 4'd7,
    FAULT  = 4'd8
  } state_e;

  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic       pc_out;
    logic       mdr_out;
    logic       zlo_out;
    logic       c_out;
    logic       ba_out;
    logic       pc_in;
    logic       mdr_in;
    logic       mar_in;
    logic       ir_in;
    logic       y_in;
    logic       zlo_in;
    logic       r_in;
    logic       inc_pc;
    logic       read;
    logic       g_ra;
    logic       g_rb;
    logic [4:0] control;
    logic       run;
    logic       fault;
  } ctrl_t;

  state_e     state_q, state_d;
  logic       stop_q, stop_d;
  logic [4:0] opcode_q, opcode_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       run_state;
  logic       stop_now;

  // Only the opcode field matters to sequencing; register fields go to the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[26:0];

  // ALU operation code for the three immediate instructions; zero otherwise.
  function automatic logic [4:0] alu_code(input logic [4:0] opcode);
    case (opcode)
      OP_ADDI: alu_code = 5'b00011;
      OP_ANDI: alu_code = 5'b01000;
      OP_ORI:  alu_code = 5'b01001;
      default: alu_code = 5'b00000;
    endcase
  endfunction

  // Strobe pattern for a given state; outputs are a pure function of state and opcode.
  function automatic ctrl_t decode(input state_e state, input logic [4:0] opcode);
    ctrl_t c;
    c = '0;
    case (state)
      T0: begin
        c.pc_out = 1'b1;
        c.mar_in = 1'b1;
        c.inc_pc = 1'b1;
      end
      T1: begin
        c.read   = 1'b1;
        c.mdr_in = 1'b1;
      end
      T2: begin
        c.mdr_out = 1'b1;
        c.ir_in   = 1'b1;
      end
      T3: begin
        c.g_rb   = 1'b1;
        c.ba_out = 1'b1;
        c.y_in   = 1'b1;
      end
      T4: begin
        c.c_out   = 1'b1;
        c.zlo_in  = 1'b1;
        c.control = alu_code(opcode);
      end
      T5: begin
        c.zlo_out = 1'b1;
        c.g_ra    = 1'b1;
        c.r_in    = 1'b1;
      end
      FAULT:   c.fault = 1'b1;
      default: c = '0;
    endcase
    c.run = (state == T0) || (state == T1) || (state == T2) ||
            (state == T3) || (state == T4) || (state == T5);
    return c;
  endfunction

  // Next-state, stop-flag and opcode-latch logic; outputs are decoded from the next state
  // so the registered strobes line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    stop_d   = stop_q;
    opcode_d = opcode_q;

    run_state = (state_q == T0) || (state_q == T1) || (state_q == T2) ||
                (state_q == T3) || (state_q == T4) || (state_q == T5);
    stop_now  = stop_q || (Stop && run_state);
    if (run_state) begin
      stop_d = stop_now;
    end

    case (state_q)
      IDLE:   if (Start) state_d = T0;
      T0:     state_d = T1;
      T1:     if (Mem_Ready) state_d = T2;
      T2: begin
        state_d  = T3;
        opcode_d = IR[31:27];
      end
      T3: begin
        case (opcode_q)
          OP_ADDI, OP_ANDI, OP_ORI: state_d = T4;
          OP_NOP:                   state_d = stop_now ? HALTED : T0;
          OP_HALT:                  state_d = HALTED;
          default:                  state_d = FAULT;
        endcase
      end
      T4:     state_d = T5;
      T5:     state_d = stop_now ? HALTED : T0;
      HALTED: if (Start) state_d = T0;
      FAULT:  state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // A pending stop is consumed by halting and has no meaning outside a run.
    if ((state_d == HALTED) || (state_d == FAULT) || (state_d == IDLE)) begin
      stop_d = 1'b0;
    end

    ctrl_d = decode(state_d, opcode_d);
  end

  // State, stop flag, latched opcode and registered strobes with synchronous clear.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q  <= IDLE;
      stop_q   <= 1'b0;
      opcode_q <= 5'b00000;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      stop_q   <= stop_d;
      opcode_q <= opcode_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign PC_Out  = ctrl_q.pc_out;
  assign MDR_Out = ctrl_q.mdr_out;
  assign ZLO_Out = ctrl_q.zlo_out;
  assign C_Out   = ctrl_q.c_out;
  assign BA_Out  = ctrl_q.ba_out;
  assign PC_In   = ctrl_q.pc_in;
  assign MDR_In  = ctrl_q.mdr_in;
  assign MAR_In  = ctrl_q.mar_in;
  assign IR_In   = ctrl_q.ir_in;
  assign Y_In    = ctrl_q.y_in;
  assign ZLO_In  = ctrl_q.zlo_in;
  assign R_In    = ctrl_q.r_in;
  assign IncPC   = ctrl_q.inc_pc;
  assign Read    = ctrl_q.read;
  assign G_RA    = ctrl_q.g_ra;
  assign G_RB    = ctrl_q.g_rb;
  assign CONTROL = ctrl_q.control;
  assign Run     = ctrl_q.run;
  assign Fault   = ctrl_q.fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: random instruction stream driven against an
// instruction-level reference model, with a scoreboard monitor checking each
// completed instruction and per-cycle invariants.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        Start;
  logic        Stop;
  logic        Mem_Ready;
  logic        PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out;
  logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In;
  logic        IncPC, Read, G_RA, G_RB;
  logic [4:0]  CONTROL;
  logic        Run, Fault;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Start(Start), .Stop(Stop),
    .Mem_Ready(Mem_Ready),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .C_Out(C_Out),
    .BA_Out(BA_Out), .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In),
    .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In), .R_In(R_In),
    .IncPC(IncPC), .Read(Read), .G_RA(G_RA), .G_RB(G_RB),
    .CONTROL(CONTROL), .Run(Run), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  typedef enum int {OUT_CONT = 0, OUT_HALT = 1, OUT_FAULT = 2} outcome_e;

  // One completed instruction as seen from outside the block.
  typedef struct {
    int         cycles;
    logic [4:0] ctrl;
    int         rins;
    int         reads;
    outcome_e   outcome;
  } rec_t;

  rec_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   monEnable  = 1'b0;

  function automatic logic [22:0] allOuts();
    return {PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, PC_In, MDR_In, MAR_In,
            IR_In, Y_In, ZLO_In, R_In, IncPC, Read, G_RA, G_RB, CONTROL, Run, Fault};
  endfunction

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout/none, expected event", name);
  endtask

  // Reference model: what one instruction looks like from outside, derived from
  // its opcode, the number of memory wait cycles and when (if ever) Stop was pulsed.
  function automatic rec_t modelInstr(input logic [4:0] opc, input int stalls, input int stopPhase);
    rec_t r;
    bit   isAlu;
    r.reads   = stalls + 1;
    r.ctrl    = 5'b00000;
    r.rins    = 0;
    isAlu     = 1'b1;
    case (opc)
      5'b01011: r.ctrl = 5'b00011;
      5'b01100: r.ctrl = 5'b01000;
      5'b01101: r.ctrl = 5'b01001;
      default:  isAlu  = 1'b0;
    endcase
    if (isAlu) begin
      r.cycles  = 6 + stalls;
      r.rins    = 1;
      r.outcome = (stopPhase >= 0 && stopPhase <= 5) ? OUT_HALT : OUT_CONT;
    end else if (opc == 5'b11010) begin
      r.cycles  = 4 + stalls;
      r.outcome = (stopPhase >= 0 && stopPhase <= 3) ? OUT_HALT : OUT_CONT;
    end else if (opc == 5'b11011) begin
      r.cycles  = 4 + stalls;
      r.outcome = OUT_HALT;
    end else begin
      r.cycles  = 4 + stalls;
      r.outcome = OUT_FAULT;
    end
    return r;
  endfunction

  // Which execution step the block is showing, recognised from its strobes.
  function automatic int phaseNow();
    if (MAR_In) return 0;
    if (Read)   return 1;
    if (IR_In)  return 2;
    if (Y_In)   return 3;
    if (ZLO_In) return 4;
    if (R_In)   return 5;
    return -1;
  endfunction

  // Drive one instruction from its T0 until the next fetch or the run ends.
  task automatic applyStimulus(input logic [31:0] ir, input int stalls, input int stopPhase,
                               output outcome_e oc, output bit ok);
    rec_t e;
    int   ph;
    int   t1Seen;
    int   n;
    bit   stopDone;
    e = modelInstr(ir[31:27], stalls, stopPhase);
    expQ.push_back(e);
    oc       = e.outcome;
    ok       = 1'b1;
    IR       = ir;
    t1Seen   = 0;
    n        = 0;
    stopDone = 1'b0;
    forever begin
      ph = phaseNow();
      if (ph == 1) begin
        Mem_Ready = (t1Seen >= stalls);
        t1Seen++;
      end else begin
        Mem_Ready = 1'($urandom % 2);
      end
      Stop = 1'b0;
      if (!stopDone && ph == stopPhase) begin
        Stop     = 1'b1;
        stopDone = 1'b1;
      end
      @(negedge Clock);
      n++;
      if (MAR_In || !Run) break;
      if (n > 40) begin
        failNow("instrTimeout");
        ok = 1'b0;
        break;
      end
    end
    Stop      = 1'b0;
    Mem_Ready = 1'b0;
  endtask

  task automatic hardRestart();
    monEnable = 1'b0;
    Stop      = 1'b0;
    Start     = 1'b0;
    Clear     = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    expQ.delete();
    monEnable = 1'b1;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Bring the block back to a fetch after an instruction that left the run.
  task automatic handleOutcome(input outcome_e oc);
    if (oc == OUT_HALT) begin
      Start = 1'b1;
      Stop  = 1'($urandom % 2);
      @(negedge Clock);
      Start = 1'b0;
      Stop  = 1'b0;
      checkOutput("restartFromHalted", MAR_In, 1);
    end else if (oc == OUT_FAULT) begin
      checkOutput("faultFlag", Fault, 1);
      Start = 1'b1;
      @(negedge Clock);
      checkOutput("faultIgnoresStart", {Fault, Run}, 2);
      Start = 1'b0;
      Clear = 1'b0;
      @(negedge Clock);
      checkOutput("faultClearedToIdle", allOuts(), 0);
      Clear = 1'b1;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      checkOutput("startAfterFault", MAR_In, 1);
    end
  endtask

  rec_t obs;
  rec_t expRec;
  bit   inInstr = 1'b0;

  // Scoreboard monitor: rebuilds each instruction from the strobes and checks it.
  always @(negedge Clock) begin
    if (!monEnable) begin
      inInstr = 1'b0;
    end else begin
      checkOutput("busExclusive",
                  ((int'(PC_Out) + int'(MDR_Out) + int'(ZLO_Out) + int'(C_Out) + int'(BA_Out)) > 1), 0);
      checkOutput("runFaultExclusive", Run & Fault, 0);
      checkOutput("controlOutsideT4", (!ZLO_In && CONTROL != 5'b00000), 0);
      if (inInstr && (IncPC || !Run)) begin
        obs.outcome = IncPC ? OUT_CONT : (Fault ? OUT_FAULT : OUT_HALT);
        if (expQ.size() == 0) begin
          failNow("unexpectedInstr");
        end else begin
          expRec = expQ.pop_front();
          checkOutput("instrCycles",  obs.cycles,       expRec.cycles);
          checkOutput("instrControl", obs.ctrl,         expRec.ctrl);
          checkOutput("instrRInCnt",  obs.rins,         expRec.rins);
          checkOutput("instrReadCnt", obs.reads,        expRec.reads);
          checkOutput("instrOutcome", int'(obs.outcome), int'(expRec.outcome));
        end
        inInstr = 1'b0;
      end
      if (IncPC) begin
        inInstr    = 1'b1;
        obs.cycles = 0;
        obs.ctrl   = 5'b00000;
        obs.rins   = 0;
        obs.reads  = 0;
      end
      if (inInstr) begin
        obs.cycles++;
        if (Read && MDR_In) obs.reads++;
        if (R_In) obs.rins++;
        if (ZLO_In) obs.ctrl = CONTROL;
      end
    end
  end

  function automatic logic [4:0] pickOpcode();
    int         r;
    logic [4:0] o;
    r = $urandom % 10;
    case (r)
      0, 1:    o = 5'b01011;
      2, 3:    o = 5'b01100;
      4, 5:    o = 5'b01101;
      6, 7:    o = 5'b11010;
      8:       o = 5'b11011;
      default: begin
        o = 5'($urandom % 32);
        while (o == 5'b01011 || o == 5'b01100 || o == 5'b01101 ||
               o == 5'b11010 || o == 5'b11011) begin
          o = 5'($urandom % 32);
        end
      end
    endcase
    return o;
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    outcome_e oc;
    bit       ok;
    int       n;
    Clear = 1'b0; Start = 1'b0; Stop = 1'b0; Mem_Ready = 1'b0; IR = 32'h0;
    repeat (2) @(negedge Clock);
    checkOutput("resetOutputs", allOuts(), 0);
    Clear = 1'b1;
    Start = 1'b0;
    @(negedge Clock);
    checkOutput("idleWithoutStart", allOuts(), 0);

    monEnable = 1'b1;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    checkOutput("startToT0", MAR_In, 1);

    // Directed instructions: ori, stalled addi, ori with Stop in T2, halt, bad opcode.
    applyStimulus(32'h6908001A, 0, -1, oc, ok);
    if (!ok) hardRestart(); else handleOutcome(oc);
    applyStimulus({5'b01011, 27'h0123456}, 3, -1, oc, ok);
    if (!ok) hardRestart(); else handleOutcome(oc);
    applyStimulus({5'b01101, 27'h0000042}, 0, 2, oc, ok);
    if (!ok) hardRestart(); else handleOutcome(oc);
    applyStimulus(32'hD8000000, 0, -1, oc, ok);
    if (!ok) hardRestart(); else handleOutcome(oc);
    applyStimulus({5'b11111, 27'h0}, 1, -1, oc, ok);
    if (!ok) hardRestart(); else handleOutcome(oc);

    // Random instruction stream.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ir;
      int          stalls;
      int          sp;
      ir     = {pickOpcode(), 27'($urandom)};
      stalls = int'($urandom % 4);
      sp     = (($urandom % 4) == 0) ? int'($urandom % 6) : -1;
      applyStimulus(ir, stalls, sp, oc, ok);
      if (!ok) hardRestart(); else handleOutcome(oc);
    end

    #1;
    checkOutput("scoreboardDrained", expQ.size(), 0);
    monEnable = 1'b0;

    // Clear during T4 aborts the instruction with no write-back strobe.
    IR        = {5'b01100, 27'h0};
    Mem_Ready = 1'b1;
    n = 0;
    while (!ZLO_In && n < 12) begin
      @(negedge Clock);
      n++;
    end
    if (!ZLO_In) begin
      failNow("reachT4");
    end else begin
      Clear = 1'b0;
      @(negedge Clock);
      checkOutput("clearInT4Outputs", allOuts(), 0);
      checkOutput("clearInT4NoRIn", R_In, 0);
      Clear = 1'b1;
      @(negedge Clock);
      checkOutput("idleAfterClear", allOuts(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low.
REQ-002 Clock  in  1  rising-edge clock for all state.
REQ-003 Clear  in  1  synchronous active-low reset.
REQ-004 IR  in  32  current instruction: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], immediate IR[18:0].
REQ-005 Start  in  1  begins fetching when sampled high in IDLE or HALTED.
REQ-006 Stop  in  1  one-cycle request to halt after the current instruction completes.
REQ-007 Mem_Ready  in  1  memory read data is valid in MDR input this cycle.
REQ-008 PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out  out  1 each  datapath bus-drive selects.
REQ-009 PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In  out  1 each  datapath register load enables.
REQ-010 IncPC, Read, G_RA, G_RB  out  1 each  PC increment, memory read, Ra select, Rb select.
REQ-011 CONTROL  out  5  ALU operation code.
REQ-012 Run  out  1  high in every state except IDLE, HALTED and FAULT.
REQ-013 Fault  out  1  high only in FAULT.

Function
REQ-014 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALTED, FAULT; all outputs SHALL be Moore-decoded from the state register plus latched opcode.
REQ-015 Output levels per state; unlisted outputs 0, CONTROL 00000 except in T4:
- T0: PC_Out, MAR_In, IncPC.
- T1: Read, MDR_In.
- T2: MDR_Out, IR_In.
- T3: G_RB, BA_Out, Y_In.
- T4: C_Out, ZLO_In, CONTROL per REQ-017.
- T5: ZLO_Out, G_RA, R_In.
REQ-016 Transitions:
- IDLE->T0 on Start.
- T0->T1.
- T1->T2 when Mem_Ready=1; T1 holds (Read, MDR_In stay high) while Mem_Ready=0.
- T2->T3.
- T3 decodes the opcode as in REQ-017.
- T4->T5.
- T5->T0, or T5->HALTED if the stop flag is set.
- HALTED->T0 on Start; FAULT holds until Clear.
REQ-017 The opcode SHALL be latched from IR at the T2->T3 edge; decode in T3:
- addi 01011 -> CONTROL 00011.
- andi 01100 -> CONTROL 01000.
- ori 01101 -> CONTROL 01001.
- nop 11010 -> next state T0 (or HALTED if the stop flag is set), skipping T4/T5.
- halt 11011 -> HALTED.
- Any other opcode -> FAULT.
REQ-018 Stop SHALL set a sticky stop flag in any Run state; the flag SHALL be cleared on entering HALTED and SHALL be ignored in IDLE, HALTED and FAULT.
REQ-019 If Start and the stop flag apply in the same cycle in HALTED, Start SHALL win and the flag SHALL be cleared.
REQ-020 Stop asserted in T5 SHALL take effect at that same T5 exit.
REQ-021 An ALU-immediate instruction with Mem_Ready high in T1 SHALL take exactly 6 cycles (T0..T5); each T1 stall cycle SHALL add one cycle.
REQ-022 IncPC SHALL be high for exactly one cycle per fetch, never during T1 stalls.
REQ-023 No two bus-drive outputs (PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out) SHALL be high in the same cycle.

Reset
REQ-024 With Clear=0 at a rising edge, the next state SHALL be IDLE, all outputs 0, CONTROL 00000, the stop flag and latched opcode cleared.
REQ-025 Clear=0 SHALL abort any state, including a T1 stall and FAULT, with no partial R_In or ZLO_In pulse after the edge.

Verification
REQ-026 Start, Mem_Ready=1, IR=0x6908001A -> states T0..T5 in 6 cycles; T4 CONTROL=01001, C_Out=1, ZLO_In=1; T5 G_RA=1, R_In=1; then T0.
REQ-027 Mem_Ready held low for 3 cycles in T1 -> T1 lasts 4 cycles with Read and MDR_In high, IncPC pulsed once; total 9 cycles.
REQ-028 IR=0xD8000000 (halt) -> T3->HALTED, Run=0; Start -> T0.
REQ-029 IR opcode 11111 -> FAULT, Fault=1, Start ignored; Clear=0 -> IDLE.
REQ-030 Stop pulse in T2 of ori -> T3, T4, T5 complete, R_In pulse seen, then HALTED.
REQ-031 Clear=0 during T4 -> next cycle IDLE, all outputs 0, no R_In pulse.
